// File: rtl/rgb_pwm_driver_if.sv
// rgb_pwm_driver_if: bundles the colour inputs, run control and PWM drive
// outputs of rgb_pwm_driver. The master side (sequencer/bench) drives
// enable and the intensity codes; the slave side (the driver) returns the
// LED lines and the frame-wrap strobe. There is no valid/ready handshake:
// inputs are level signals sampled by the driver on its own schedule, and
// frame_start is an unconditional one-cycle strobe.
interface rgb_pwm_driver_if;
  logic       enable;
  logic [3:0] r_in;
  logic [3:0] g_in;
  logic [3:0] b_in;
  logic       led_r;
  logic       led_g;
  logic       led_b;
  logic       frame_start;

  modport master (
    output enable,
    output r_in,
    output g_in,
    output b_in,
    input  led_r,
    input  led_g,
    input  led_b,
    input  frame_start
  );

  modport slave (
    input  enable,
    input  r_in,
    input  g_in,
    input  b_in,
    output led_r,
    output led_g,
    output led_b,
    output frame_start
  );
endinterface

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: three-channel PWM LED output stage. Each 4-bit level is
// the number of PWM steps (out of 15) the channel is on per frame; a step
// lasts PRESCALE clocks. Colour values are captured only at the frame wrap
// (or transparently while stopped), so upstream changes never cut a pulse
// short. frame_start pulses in the first cycle of each new frame.
// Build option: define RGB_PWM_ACTIVE_LOW_EN to invert the three LED
// outputs for common-anode LEDs (idle level becomes 1; frame_start keeps
// its active-high polarity).
module rgb_pwm_driver #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clock,
  input  logic             reset,
  rgb_pwm_driver_if.slave  bus
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [3:0]    STEP_LAST  = 4'd14;

`ifdef RGB_PWM_ACTIVE_LOW_EN
  localparam logic LED_OFF = 1'b1;
`else
  localparam logic LED_OFF = 1'b0;
`endif

  logic [PW-1:0] presc_cnt;
  logic [3:0]    step_cnt;
  logic [3:0]    duty_r;
  logic [3:0]    duty_g;
  logic [3:0]    duty_b;
  logic          led_r_reg;
  logic          led_g_reg;
  logic          led_b_reg;
  logic          frame_start_reg;

  logic tick;
  logic wrap;

  // One PWM step ends when the prescaler reaches its last count; the frame
  // ends on the last step's tick.
  assign tick = (presc_cnt == PRESC_LAST);
  assign wrap = tick && (step_cnt == STEP_LAST);

  // Counters, shadow duty registers and registered drive outputs. While
  // stopped the shadows follow the inputs so a restart begins at step 0
  // with the colour present in the last stopped cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_cnt       <= '0;
      step_cnt        <= '0;
      duty_r          <= '0;
      duty_g          <= '0;
      duty_b          <= '0;
      led_r_reg       <= LED_OFF;
      led_g_reg       <= LED_OFF;
      led_b_reg       <= LED_OFF;
      frame_start_reg <= 1'b0;
    end else if (!bus.enable) begin
      presc_cnt       <= '0;
      step_cnt        <= '0;
      duty_r          <= bus.r_in;
      duty_g          <= bus.g_in;
      duty_b          <= bus.b_in;
      led_r_reg       <= LED_OFF;
      led_g_reg       <= LED_OFF;
      led_b_reg       <= LED_OFF;
      frame_start_reg <= 1'b0;
    end else begin
      if (tick) begin
        presc_cnt <= '0;
      end else begin
        presc_cnt <= presc_cnt + PW'(1);
      end

      if (wrap) begin
        step_cnt        <= '0;
        duty_r          <= bus.r_in;
        duty_g          <= bus.g_in;
        duty_b          <= bus.b_in;
        frame_start_reg <= 1'b1;
      end else begin
        frame_start_reg <= 1'b0;
        if (tick) begin
          step_cnt <= step_cnt + 4'd1;
        end
      end

      // The on-phase runs from the frame head for duty steps; level 15 is
      // always on because step_cnt never exceeds 14.
      led_r_reg <= (step_cnt < duty_r) ^ LED_OFF;
      led_g_reg <= (step_cnt < duty_g) ^ LED_OFF;
      led_b_reg <= (step_cnt < duty_b) ^ LED_OFF;
    end
  end

  assign bus.led_r       = led_r_reg;
  assign bus.led_g       = led_g_reg;
  assign bus.led_b       = led_b_reg;
  assign bus.frame_start = frame_start_reg;

endmodule
